// File: rtl/regfile_pkg.sv
// Shared constants for the decode-stage register file: FSM encoding, default sizes,
// and the address-validity rule used by both read ports and the write port.
package regfile_pkg;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_CLEAR = 1'b1;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_DEPTH      = 32;

    // An address is usable when it lies inside the array and is not a hardwired $zero.
    function automatic logic addr_ok(input int addr, input int depth, input logic zero_reg);
        return (addr < depth) && !(zero_reg && (addr == 0));
    endfunction

endpackage

// File: rtl/regfile_clr_seq.sv
// Clear sequencer: sweeps zeros through the array one entry per cycle after reset
// or a clr request, and holds busy for the duration of the sweep.
module regfile_clr_seq
    import regfile_pkg::*;
#(
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        // A clr request always restarts the sweep, even one already in progress.
        if (clr) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end else if (state_q == ST_CLEAR) begin
            if (cnt_q == LAST) begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + ADDR_WIDTH'(1);
            end
        end
        busy_d = (state_d == ST_CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign busy     = busy_q;
    assign clr_we   = (state_q == ST_CLEAR);
    assign clr_addr = cnt_q;

endmodule

// File: rtl/registerfile_mp.sv
// Decode-stage register file: one write port, two combinational read ports, hardware clear.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto the read ports.
module registerfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = $clog2(DEPTH),
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] rd,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rt,
    output logic [DATA_WIDTH-1:0] a,
    output logic [DATA_WIDTH-1:0] b,
    output logic                  busy
);

    localparam logic ZR = (ZERO_REG != 0);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  sweep_we;
    logic [ADDR_WIDTH-1:0] sweep_addr;
    logic                  wr_en;
    logic                  rs_ok, rt_ok;

    regfile_clr_seq #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clr_seq (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .busy     (busy),
        .clr_we   (sweep_we),
        .clr_addr (sweep_addr)
    );

    assign wr_en = we && !busy && !clr && addr_ok(32'(rd), DEPTH, ZR);
    assign rs_ok = !busy && addr_ok(32'(rs), DEPTH, ZR);
    assign rt_ok = !busy && addr_ok(32'(rt), DEPTH, ZR);

    // No reset on the storage so it can map to distributed RAM; the sweep zeroes it.
    always_ff @(posedge clk) begin
        if (sweep_we) begin
            mem_q[sweep_addr] <= '0;
        end else if (wr_en) begin
            mem_q[rd] <= data;
        end
    end

    always_comb begin
        a = '0;
        if (rs_ok) begin
            a = mem_q[rs];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rs == rd)) a = data;
`endif
        end
    end

    always_comb begin
        b = '0;
        if (rt_ok) begin
            b = mem_q[rt];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (rt == rd)) b = data;
`endif
        end
    end

endmodule

// File: doc/registerfile_mp.md
Name: registerfile_mp

Overview:
- Parametrised successor to the CPU's 32x32 register file: one write port (rd/data/we) and two asynchronous read ports (rs->a, rt->b).
- Adds an asynchronous active-high reset and a hardware clear sequencer. The sequencer zeroes the array one entry per cycle, so the array can map to distributed RAM without a reset on every flop.
- Sits in the decode stage of the MIPS datapath. busy stalls the pipeline while a clear is in progress.

Parameters:
- DATA_WIDTH, 32, width of each register and of data/a/b.
- DEPTH, 32, number of registers; must be at least 2; need not be a power of two.
- ADDR_WIDTH, $clog2(DEPTH), width of rs/rt/rd; derived, do not override.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero (MIPS $zero); when 0 it is an ordinary register.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous clear request; sampled on the rising edge.
- we  input  1  write enable.
- rd  input  ADDR_WIDTH  write address.
- data  input  DATA_WIDTH  write data.
- rs  input  ADDR_WIDTH  read address, port A.
- rt  input  ADDR_WIDTH  read address, port B.
- a  output  DATA_WIDTH  read data, port A (combinational).
- b  output  DATA_WIDTH  read data, port B (combinational).
- busy  output  1  high while the clear sweep runs; writes are ignored while busy.

Behaviour:
- State machine has two states, IDLE and CLEAR, plus a sweep counter cnt of ADDR_WIDTH bits.
- rst asserted (asynchronous): state=CLEAR, cnt=0, busy=1. Array contents are not reset directly; the sweep zeroes them.
- CLEAR, each edge: write 0 to mem[cnt]. If cnt==DEPTH-1, go to IDLE; otherwise cnt+1.
- busy is 1 for exactly DEPTH cycles after rst deasserts, then 0.
- busy = (state==CLEAR), registered. Reset value of busy is 1.
- IDLE with clr=1 at an edge: enter CLEAR with cnt=0. busy rises after that edge. Any write in that same cycle is dropped; clr has priority.
- clr=1 while in CLEAR: restart the sweep with cnt=0, so busy is held for a further DEPTH cycles.
- Write condition: we && !busy && !clr && rd<DEPTH && !(ZERO_REG && rd==0). When true, mem[rd]<=data on the edge. Otherwise the write is silently dropped.
- Read port A: a = 0 if busy, or rs>=DEPTH, or (ZERO_REG && rs==0); otherwise a = mem[rs]. Port B follows the same rule with rt/b.
- Read latency is zero (combinational). Written data is visible on a/b from the cycle after the write edge (no-bypass build).
- Same-cycle read and write of one address: the read returns the old contents unless the bypass feature is compiled in.
- rs==rt is legal; a and b are then identical.
- Reset mid-sweep restarts at cnt=0. Reset mid-write: that write is lost.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-to-read forwarding. If the write condition holds this cycle and rs==rd, then a=data combinationally; the same applies to rt/b.
- The ZERO_REG, busy and out-of-range rules still override the bypass.
- Undefined: no forwarding; read-during-write returns the old value, as above.

Decomposition:
- Shared package regfile_pkg holds:
  - the state encoding constants ST_IDLE=1'b0 and ST_CLEAR=1'b1;
  - the default DATA_WIDTH/DEPTH values reused by the datapath.
- One natural sub-module, regfile_clr_seq, owns the FSM, cnt and busy. It outputs clr_we and clr_addr to the array.
- The storage array and read muxes stay in registerfile_mp.

Test Plan:
- Reset, 20 ns clock, DEPTH=32: pulse rst, then release -> busy=1 for exactly 32 cycles, then 0. a=b=0 throughout. After busy falls, reading all 32 addresses returns 0.
- Basic write/read: we=1, rd=31, data=2001; next cycle rd=2, data=4001, rs=31 -> a=2001 after the first edge. Set rt=2 -> b=4001 after the second edge.
- Zero register and drop rules:
  - ZERO_REG=1, write rd=0 data=5001, rs=0 -> a=0.
  - we=0, rd=6, data=3001 -> mem[6] unchanged (reads 0).
  - DEPTH=24, write rd=30 -> dropped; rs=30 -> a=0.
- Clear: registers 8=3001 and 30=5001 loaded; assert clr with we=1, rd=8, data=7 in the same cycle -> write dropped. busy goes high for 32 cycles. Afterwards rs=8, rt=30 -> a=b=0. A write attempted mid-sweep is ignored.
- Mid-sweep events:
  - clr re-asserted at cnt=10 -> busy held for 32 further cycles.
  - rst asserted at cnt=20 -> busy stays 1, cnt restarts at 0, 32 cycles from release.
- Bypass (build with and without REGFILE_BYPASS_EN): mem[2]=4001; same cycle we=1, rd=2, data=9, rs=2:
  - defined -> a=9 before the edge;
  - undefined -> a=4001 before the edge, 9 after.
